// File: rtl/systolic_mac_pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
package systolic_pkg;

  typedef enum logic {PE_WS = 1'b0, PE_OS = 1'b1} pe_mode_t;

  typedef enum logic [1:0] {S_WS, S_OS_EMPTY, S_OS_ACC} pe_state_t;

  localparam int NUM_LEGAL_WBITS = 4;
  localparam int LEGAL_WBITS [NUM_LEGAL_WBITS] = '{1, 2, 4, 8};

  function automatic bit wbits_legal(input int wbits);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_WBITS; i++)
      if (LEGAL_WBITS[i] == wbits) ok = 1'b1;
    return ok;
  endfunction

  // Signed add clamped to the signed range of a width-bit word.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (width - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s[31:0];
  endfunction

endpackage

// File: rtl/systolic_mac_pe_weight_mult.sv
// Combinational signed activation x weight multiplier for 1/2/4/8-bit weights,
// followed by an arithmetic right shift of FracBits and truncation to BitSize.
module pe_weight_mult import systolic_pkg::*; #(
  parameter int BitSize        = 8,
  parameter int Weight_BitSize = 8,
  parameter int FracBits       = 0
) (
  input  logic [BitSize-1:0]        a,
  input  logic [Weight_BitSize-1:0] w,
  output logic [BitSize-1:0]        prod
);

  localparam int PW = BitSize + Weight_BitSize + 1;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] full;

  assign a_x = PW'($signed(a));

  generate
    if (!wbits_legal(Weight_BitSize)) begin : g_bad_wbits
      $error("pe_weight_mult: Weight_BitSize must be 1, 2, 4 or 8");
    end

    // A 1-bit weight encodes +/-1 rather than two's complement 0/-1.
    if (Weight_BitSize == 1) begin : g_bin
      assign full = w[0] ? a_x : -a_x;
    end else begin : g_tc
      logic signed [PW-1:0] w_x;
      assign w_x  = PW'($signed(w));
      assign full = a_x * w_x;
    end
  endgenerate

  assign prod = BitSize'(full >>> FracBits);

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC PE: double-buffered weight, WS/OS dataflow, valid propagation, OS drain.
// Build option: define SYSTOLIC_PE_SAT_EN for saturating adds and the sticky out_sat port.
module systolic_mac_pe import systolic_pkg::*; #(
  parameter int BitSize        = 8,
  parameter int M_W_BitSize    = 8,
  parameter int Weight_BitSize = 8,
  parameter int FracBits       = 0
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   in_mode,
  input  logic                   in_valid,
  input  logic [BitSize-1:0]     in_a,
  input  logic [M_W_BitSize-1:0] in_b,
  input  logic                   in_swap,
  input  logic                   in_drain,
  input  logic                   in_ps_valid,
  input  logic [BitSize-1:0]     in_partial_sum,
  output logic [BitSize-1:0]     out_a,
  output logic                   out_a_valid,
  output logic [M_W_BitSize-1:0] out_b,
  output logic                   out_swap,
  output logic                   out_drain,
  output logic [BitSize-1:0]     out_partial_sum,
  output logic                   out_ps_valid,
  output logic                   out_err
`ifdef SYSTOLIC_PE_SAT_EN
  , output logic                 out_sat
`endif
);

  localparam int WB = Weight_BitSize;

  pe_state_t          state_p1, state_nxt;
  pe_mode_t           mode;
  logic [WB-1:0]      w_act_p1;
  logic [WB-1:0]      w_eff;
  logic [BitSize-1:0] acc_p1, acc_nxt;
  logic [BitSize-1:0] prod;
  logic [BitSize-1:0] ws_sum, acc_sum;
  logic [BitSize-1:0] ps_nxt;
  logic               psv_nxt;
  logic               err_nxt;
`ifdef SYSTOLIC_PE_SAT_EN
  logic               sat_nxt;
  logic               ws_ovf, acc_ovf;
`endif

  function automatic logic [BitSize-1:0] add_fn(input logic [BitSize-1:0] x,
                                               input logic [BitSize-1:0] y);
`ifdef SYSTOLIC_PE_SAT_EN
    return BitSize'(sat_add(32'($signed(x)), 32'($signed(y)), BitSize));
`else
    return x + y;
`endif
  endfunction

  assign mode = pe_mode_t'(in_mode);

  // The swap cycle already computes with the incoming shadow weight.
  assign w_eff = in_swap ? out_b[WB-1:0] : w_act_p1;

  pe_weight_mult #(
    .BitSize       (BitSize),
    .Weight_BitSize(WB),
    .FracBits      (FracBits)
  ) u_mult (
    .a   (in_a),
    .w   (w_eff),
    .prod(prod)
  );

  assign ws_sum  = add_fn(in_partial_sum, prod);
  assign acc_sum = add_fn(acc_p1, prod);
`ifdef SYSTOLIC_PE_SAT_EN
  assign ws_ovf  = ws_sum  != (in_partial_sum + prod);
  assign acc_ovf = acc_sum != (acc_p1 + prod);
`endif

  always_comb begin
    state_nxt = state_p1;
    acc_nxt   = acc_p1;
    ps_nxt    = out_partial_sum;
    psv_nxt   = 1'b0;
    err_nxt   = out_err;
`ifdef SYSTOLIC_PE_SAT_EN
    sat_nxt   = out_sat;
`endif
    case (state_p1)
      S_WS: begin
        if (in_valid) begin
          ps_nxt  = ws_sum;
          psv_nxt = 1'b1;
`ifdef SYSTOLIC_PE_SAT_EN
          sat_nxt = out_sat | ws_ovf;
`endif
        end
        if (mode == PE_OS) state_nxt = S_OS_EMPTY;
      end
      S_OS_EMPTY: begin
        if (in_drain) begin
          ps_nxt  = '0;
          psv_nxt = 1'b1;
          if (in_ps_valid) err_nxt = 1'b1;
        end else if (in_ps_valid) begin
          ps_nxt  = in_partial_sum;
          psv_nxt = 1'b1;
        end
        if (mode == PE_WS) begin
          state_nxt = S_WS;
        end else if (in_valid) begin
          acc_nxt   = prod;
          state_nxt = S_OS_ACC;
        end
      end
      S_OS_ACC: begin
        // Mode is frozen here; only a drain without new data leaves the state.
        if (in_drain) begin
          ps_nxt  = acc_p1;
          psv_nxt = 1'b1;
          if (in_ps_valid) err_nxt = 1'b1;
          if (in_valid) begin
            acc_nxt = prod;
          end else begin
            acc_nxt   = '0;
            state_nxt = S_OS_EMPTY;
          end
        end else begin
          if (in_ps_valid) begin
            ps_nxt  = in_partial_sum;
            psv_nxt = 1'b1;
          end
          if (in_valid) begin
            acc_nxt = acc_sum;
`ifdef SYSTOLIC_PE_SAT_EN
            sat_nxt = out_sat | acc_ovf;
`endif
          end
        end
      end
      default: state_nxt = S_WS;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_p1 <= S_WS;
    else        state_p1 <= state_nxt;
  end

  // Stage p1: forwarded chains, active weight, accumulator and results.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_a           <= '0;
      out_a_valid     <= 1'b0;
      out_b           <= '0;
      out_swap        <= 1'b0;
      out_drain       <= 1'b0;
      out_partial_sum <= '0;
      out_ps_valid    <= 1'b0;
      out_err         <= 1'b0;
      w_act_p1        <= '0;
      acc_p1          <= '0;
`ifdef SYSTOLIC_PE_SAT_EN
      out_sat         <= 1'b0;
`endif
    end else begin
      out_b           <= in_b;
      out_swap        <= in_swap;
      out_drain       <= in_drain;
      out_a_valid     <= in_valid;
      if (in_valid) out_a <= in_a;
      if (in_swap)  w_act_p1 <= out_b[WB-1:0];
      acc_p1          <= acc_nxt;
      out_partial_sum <= ps_nxt;
      out_ps_valid    <= psv_nxt;
      out_err         <= err_nxt;
`ifdef SYSTOLIC_PE_SAT_EN
      out_sat         <= sat_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed, table-driven bench for systolic_mac_pe (8-bit weight instance plus a 1-bit weight instance).
module tb_systolic_mac_pe;

  typedef struct {
    logic       mode;
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
    logic       swap;
    logic       drain;
    logic       psv;
    logic [7:0] ps;
    logic       e_psv;
    logic [7:0] e_ps;
    logic [7:0] e_a;
    logic       e_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res_n;
  logic       in_mode, in_valid, in_swap, in_drain, in_ps_valid;
  logic [7:0] in_a, in_b, in_partial_sum;
  logic [7:0] out_a, out_b, out_partial_sum;
  logic       out_a_valid, out_swap, out_drain, out_ps_valid, out_err;

  logic       v1_valid, v1_swap;
  logic [7:0] v1_a, v1_b, v1_ps;
  logic [7:0] o1_a, o1_b, o1_ps;
  logic       o1_av, o1_swap, o1_drain, o1_psv, o1_err;

`ifdef SYSTOLIC_PE_SAT_EN
  logic out_sat, o1_sat;
`endif

  int pass_cnt = 0;
  int total    = 0;

  systolic_mac_pe #(.BitSize(8), .M_W_BitSize(8), .Weight_BitSize(8), .FracBits(0)) dut (
    .clk(clk), .res_n(res_n), .in_mode(in_mode), .in_valid(in_valid), .in_a(in_a),
    .in_b(in_b), .in_swap(in_swap), .in_drain(in_drain), .in_ps_valid(in_ps_valid),
    .in_partial_sum(in_partial_sum), .out_a(out_a), .out_a_valid(out_a_valid),
    .out_b(out_b), .out_swap(out_swap), .out_drain(out_drain),
    .out_partial_sum(out_partial_sum), .out_ps_valid(out_ps_valid), .out_err(out_err)
`ifdef SYSTOLIC_PE_SAT_EN
    , .out_sat(out_sat)
`endif
  );

  systolic_mac_pe #(.BitSize(8), .M_W_BitSize(8), .Weight_BitSize(1), .FracBits(0)) dut1 (
    .clk(clk), .res_n(res_n), .in_mode(1'b0), .in_valid(v1_valid), .in_a(v1_a),
    .in_b(v1_b), .in_swap(v1_swap), .in_drain(1'b0), .in_ps_valid(1'b0),
    .in_partial_sum(v1_ps), .out_a(o1_a), .out_a_valid(o1_av),
    .out_b(o1_b), .out_swap(o1_swap), .out_drain(o1_drain),
    .out_partial_sum(o1_ps), .out_ps_valid(o1_psv), .out_err(o1_err)
`ifdef SYSTOLIC_PE_SAT_EN
    , .out_sat(o1_sat)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic mode, input logic vld, input logic [7:0] a,
                              input logic [7:0] b, input logic swap, input logic drain,
                              input logic psv, input logic [7:0] ps, input logic e_psv,
                              input logic [7:0] e_ps, input logic [7:0] e_a, input logic e_err);
    vec_t v;
    v.mode = mode; v.vld = vld; v.a = a; v.b = b; v.swap = swap; v.drain = drain;
    v.psv = psv; v.ps = ps; v.e_psv = e_psv; v.e_ps = e_ps; v.e_a = e_a; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    in_mode = v.mode; in_valid = v.vld; in_a = v.a; in_b = v.b; in_swap = v.swap;
    in_drain = v.drain; in_ps_valid = v.psv; in_partial_sum = v.ps;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    res_n = 1'b0;
    in_mode = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_swap = 1'b0;
    in_drain = 1'b0; in_ps_valid = 1'b0; in_partial_sum = 8'h00;
    v1_valid = 1'b0; v1_swap = 1'b0; v1_a = 8'h00; v1_b = 8'h00; v1_ps = 8'h00;

    //         mode  vld   a      b      swap  drain psv   ps     e_psv e_ps   e_a    e_err
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h05, 8'h03, 1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 8'h19, 8'h05, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h09, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h05, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFE, 8'h03, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 8'hFE, 8'hFE, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h07, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'h16, 8'h07, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h07, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h07, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h04, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 8'h04, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0A, 8'h01, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 8'h21, 8'h01, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h05, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h05, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 8'h0A, 8'h05, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h05, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h05, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 8'h07, 8'h03, 1'b1));

    // Reset state
    tick(); tick();
    chk("rst_out_a", out_a, 8'h00);
    chk("rst_out_b", out_b, 8'h00);
    chk("rst_ps", out_partial_sum, 8'h00);
    chk("rst_psv", 8'(out_ps_valid), 8'h00);
    chk("rst_err", 8'(out_err), 8'h00);
    chk("rst_av", 8'(out_a_valid), 8'h00);
    @(negedge clk);
    res_n = 1'b1;

    // 1-bit weight instance: 0 -> -1, 1 -> +1
    @(negedge clk); v1_b = 8'h00;
    tick();
    @(negedge clk); v1_swap = 1'b1; v1_valid = 1'b1; v1_a = 8'h03; v1_ps = 8'h0A;
    tick();
    chk("w1_neg_ps", o1_ps, 8'h07);
    chk("w1_neg_psv", 8'(o1_psv), 8'h01);
    @(negedge clk); v1_swap = 1'b0; v1_valid = 1'b0; v1_b = 8'h01;
    tick();
    @(negedge clk); v1_swap = 1'b1; v1_valid = 1'b1;
    tick();
    chk("w1_pos_ps", o1_ps, 8'h0D);
    @(negedge clk); v1_swap = 1'b0; v1_valid = 1'b0;

    // Main table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("row%0d_psv", i), 8'(out_ps_valid), 8'(tbl[i].e_psv));
      if (tbl[i].e_psv) chk($sformatf("row%0d_ps", i), out_partial_sum, tbl[i].e_ps);
      chk($sformatf("row%0d_a", i), out_a, tbl[i].e_a);
      chk($sformatf("row%0d_av", i), 8'(out_a_valid), 8'(tbl[i].vld));
      chk($sformatf("row%0d_b", i), out_b, tbl[i].b);
      chk($sformatf("row%0d_swap", i), 8'(out_swap), 8'(tbl[i].swap));
      chk($sformatf("row%0d_drain", i), 8'(out_drain), 8'(tbl[i].drain));
      chk($sformatf("row%0d_err", i), 8'(out_err), 8'(tbl[i].e_err));
    end

    // Overflow: w=1, 127+1 and -128-1
    drive(mk(1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    drive(mk(1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
`ifdef SYSTOLIC_PE_SAT_EN
    chk("sat_pos", out_partial_sum, 8'h7F);
    chk("sat_flag", 8'(out_sat), 8'h01);
`else
    chk("wrap_pos", out_partial_sum, 8'h80);
`endif
    drive(mk(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
`ifdef SYSTOLIC_PE_SAT_EN
    chk("sat_neg", out_partial_sum, 8'h80);
    chk("sat_sticky", 8'(out_sat), 8'h01);
`else
    chk("wrap_neg", out_partial_sum, 8'h7F);
`endif

    // Reset in the middle of an OS accumulation
    drive(mk(1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    drive(mk(1'b1, 1'b1, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("arst_a", out_a, 8'h00);
    chk("arst_b", out_b, 8'h00);
    chk("arst_err", 8'(out_err), 8'h00);
    chk("arst_ps", out_partial_sum, 8'h00);
`ifdef SYSTOLIC_PE_SAT_EN
    chk("arst_sat", 8'(out_sat), 8'h00);
`endif
    drive(mk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    res_n = 1'b1;
    tick();
    drive(mk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    chk("post_rst_drain_ps", out_partial_sum, 8'h00);
    chk("post_rst_drain_psv", 8'(out_ps_valid), 8'h01);
    drive(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    drive(mk(1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    chk("post_rst_wzero_ps", out_partial_sum, 8'h03);
    chk("post_rst_wzero_psv", 8'(out_ps_valid), 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
Next-generation systolic processing element for the matrix-multiply arrays in the CNN hidden and dense layers. It adds four things over the current PE:
- Double-buffered weights: a shadow chain is loaded while the active weight computes.
- A runtime-selectable dataflow: weight-stationary (WS) or output-stationary (OS) with a local accumulator.
- Explicit valid propagation on every output.
- A drain chain for OS results.

Weight precision is fixed at elaboration, as in the existing multiprecision layers.

Parameters:
BitSize, 8, width of activations, partial sums and the accumulator.
M_W_BitSize, 8, width of the weight shift chain (in_b/out_b).
Weight_BitSize, 8, stored weight width; legal values 1, 2, 4, 8 (elaboration error otherwise).
FracBits, 0, fixed-point fraction bits of the weight; the product is arithmetic-shifted right by FracBits.

Ports:
clk  in  1  clock
res_n  in  1  reset; asynchronous, active-low
in_mode  in  1  0 = WS, 1 = OS
in_valid  in  1  in_a is valid this cycle
in_a  in  BitSize  activation, signed
in_b  in  M_W_BitSize  weight shift-chain input
in_swap  in  1  copy the shadow weight into the active weight
in_drain  in  1  OS: emit the accumulator
in_ps_valid  in  1  in_partial_sum is valid
in_partial_sum  in  BitSize  upstream partial sum or drained value
out_a  out  BitSize  registered in_a
out_a_valid  out  1  registered in_valid
out_b  out  M_W_BitSize  registered in_b (this is the shadow weight)
out_swap  out  1  registered in_swap
out_drain  out  1  registered in_drain
out_partial_sum  out  BitSize  WS result or OS drained/forwarded value
out_ps_valid  out  1  out_partial_sum is valid
out_err  out  1  sticky drain-collision flag

Behaviour:
- Reset (async assert, sync release): all outputs 0, active weight 0, accumulator 0, state S_WS.
- Weight chain:
  - out_b <= in_b every cycle, unconditionally; out_swap <= in_swap.
  - The shadow weight is out_b[Weight_BitSize-1:0].
  - When in_swap=1, the active weight becomes the shadow weight. The MAC in that same cycle already uses the new weight (combinational bypass).
- Product: signed(in_a) × w, then >>> FracBits, truncated to BitSize.
  - 1-bit w: 0 = -1, 1 = +1.
  - 2/4/8-bit w: two's complement.
- Data path: out_a <= in_a and out_a_valid <= in_valid. out_a holds its value when in_valid=0.
- FSM states: S_WS, S_OS_EMPTY, S_OS_ACC.
  - in_mode is honoured only in S_WS or S_OS_EMPTY. in_mode=1 moves S_WS to S_OS_EMPTY; in_mode=0 moves S_OS_EMPTY to S_WS.
  - In S_OS_ACC, in_mode changes are ignored until after a drain.
- S_WS:
  - On in_valid: out_partial_sum <= in_partial_sum + prod and out_ps_valid <= 1. Otherwise out_ps_valid <= 0.
  - Latency is 1 cycle.
  - in_ps_valid is ignored in WS.
- S_OS_EMPTY:
  - in_valid: acc <= prod, go to S_OS_ACC.
  - in_drain: emit 0 with out_ps_valid=1.
- S_OS_ACC:
  - in_valid: acc <= acc + prod.
  - in_drain: out_partial_sum <= acc, out_ps_valid <= 1.
    - With in_valid in the same cycle: acc <= prod, stay in S_OS_ACC.
    - Without in_valid: acc <= 0, go to S_OS_EMPTY.
- OS forwarding:
  - Without in_drain: in_ps_valid forwards in_partial_sum to out_partial_sum with out_ps_valid=1.
  - in_drain and in_ps_valid in the same cycle: the local acc wins, the upstream value is dropped, and out_err is set. out_err clears only on reset.
- out_drain <= in_drain in every mode.
- Arithmetic is wrap-around modulo 2^BitSize unless SYSTOLIC_PE_SAT_EN is defined.
- Reset mid-accumulation discards acc; there is no partial output.

Optional Feature:
SYSTOLIC_PE_SAT_EN.
- Defined: every add (WS sum, OS acc) saturates to signed [-2^(BitSize-1), 2^(BitSize-1)-1]. A sticky out_sat output is added; it clears on reset.
- Undefined: two's-complement wrap; no out_sat port.

Decomposition:
- Package systolic_pkg holds:
  - pe_mode_t {PE_WS, PE_OS};
  - pe_state_t {S_WS, S_OS_EMPTY, S_OS_ACC};
  - the constant list of legal Weight_BitSize values;
  - function sat_add(a, b, width).
- One sub-module, pe_weight_mult: combinational signed multiplier covering 1/2/4/8-bit weights plus the FracBits shift. It replaces the per-width multipliers.

Test Plan:
- Weight load and swap: shift in_b=0x03 then pulse in_swap; WS, in_a=5, in_partial_sum=10, in_valid=1 in the swap cycle -> next cycle out_partial_sum=25, out_ps_valid=1, out_swap=1.
- WS bubble: in_valid=0 -> out_ps_valid=0 and out_a holds its previous value.
- OS accumulate: w=2, in_mode=1, in_a=1,2,3 over three cycles, then in_drain -> out_partial_sum=12 for one cycle; state S_OS_EMPTY; out_drain asserted one cycle after in_drain.
- Drain with simultaneous in_valid: acc=12, in_drain=1, in_valid=1, in_a=4, w=2 -> output 12; acc=8; stays in S_OS_ACC.
- Collision: OS, in_drain=1 and in_ps_valid=1 with in_partial_sum=7 -> own acc emitted, 7 dropped, out_err=1 and it stays set.
- 1-bit weight and saturation: Weight_BitSize=1, w=0, in_a=3, in_partial_sum=10 -> 7; with SYSTOLIC_PE_SAT_EN, BitSize=8, 127+1 -> 127 and out_sat=1; without it -> -128.
